// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   A start pulse in IDLE captures bin_in; IN_W cycles later the packed BCD
//   result is loaded into bcd_out together with the overflow flag, and done
//   pulses for one cycle. bcd_out/overflow change only on a done edge or reset.
//
//   Optional feature macro: BIN2BCD_LEADING_BLANK_EN
//     defined   : leading zero digits above digit 0 are output as 4'hF (blank);
//                 reset value of bcd_out is F..F0.
//     undefined : leading zeros are output as 4'h0; reset value is all zeros.
//
//   Ports
//     clk      in   clock, rising edge
//     rst      in   asynchronous active-high reset
//     start    in   conversion request, sampled only in IDLE
//     bin_in   in   IN_W-bit unsigned value, captured on the accepted start edge
//     busy     out  high while a conversion is in progress
//     done     out  one-cycle pulse, bcd_out/overflow newly valid
//     bcd_out  out  packed BCD, digit 0 in bits [3:0]
//     overflow out  last accepted bin_in exceeded 10^DIGITS-1
//
//   Handshake: start is a level sampled at each rising edge while the FSM is
//   in IDLE (busy=0); a sampled 1 is an accepted request. There is no ready
//   back-pressure beyond busy: requests seen while busy are dropped.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int IN_W   = 20,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;
   localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
`ifdef BIN2BCD_LEADING_BLANK_EN
   localparam logic [BCD_W-1:0] BCD_RST = {{(DIGITS-1){4'hF}}, 4'h0};
`else
   localparam logic [BCD_W-1:0] BCD_RST = '0;
`endif

   typedef enum logic {IDLE, CONV} state_t;

   state_t              state_q;
   logic [IN_W-1:0]     shift_q;
   logic [BCD_W-1:0]    scratch_q;
   logic [BCD_W-1:0]    scratch_d;
   logic [BCD_W-1:0]    adj;
   logic [CNT_W-1:0]    cnt_q;
   logic                ovf_next_q;

   // One double-dabble step: add 3 to digits >= 5, then shift in the next
   // binary MSB. The top scratch bit falls off; saturation covers that case.
   always_comb begin
      adj = scratch_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch_q[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
      scratch_d = {adj[BCD_W-2:0], shift_q[IN_W-1]};
   end

   // Final digit pattern for the output register: saturated value or the
   // converted digits, optionally with leading zeros blanked.
   function automatic logic [BCD_W-1:0] format_result(input logic [BCD_W-1:0] s,
                                                      input logic sat);
      logic [BCD_W-1:0] r;
`ifdef BIN2BCD_LEADING_BLANK_EN
      logic lead;
`endif
      r = sat ? ALL_NINES : s;
`ifdef BIN2BCD_LEADING_BLANK_EN
      lead = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         if (lead && (r[4*d +: 4] == 4'h0))
            r[4*d +: 4] = 4'hF;
         else
            lead = 1'b0;
      end
`endif
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_next_q <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bcd_out    <= BCD_RST;
         overflow   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  shift_q    <= bin_in;
                  scratch_q  <= '0;
                  cnt_q      <= '0;
                  ovf_next_q <= (64'(bin_in) > MAX_VAL);
                  busy       <= 1'b1;
                  state_q    <= CONV;
               end
            end
            CONV: begin
               scratch_q <= scratch_d;
               shift_q   <= shift_q << 1;
               cnt_q     <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(IN_W - 1)) begin
                  bcd_out  <= format_result(scratch_d, ovf_next_q);
                  overflow <= ovf_next_q;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Bench for bin2bcd_seq: directed vector table, hand-written multi-cycle
//   sequences (ignored starts, back-to-back, reset abort, held start) and
//   random values checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

   localparam int IN_W   = 20;
   localparam int DIGITS = 6;
   localparam int BCD_W  = 4 * DIGITS;

   logic             clk;
   logic             rst;
   logic             start;
   logic [IN_W-1:0]  bin_in;
   logic             busy;
   logic             done;
   logic [BCD_W-1:0] bcd_out;
   logic             overflow;

   int checks;
   int failures;

   logic [BCD_W:0] exp_q[$];

   typedef struct {
      logic [IN_W-1:0]  bin;
      logic [BCD_W-1:0] bcd;
      logic             ovf;
   } vec_t;

   vec_t tbl[7];

`ifdef BIN2BCD_LEADING_BLANK_EN
   localparam logic [BCD_W-1:0] BCD_RST = 24'hFFFFF0;
`else
   localparam logic [BCD_W-1:0] BCD_RST = 24'h000000;
`endif

   bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd_out),
      .overflow (overflow)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Digits by decimal division, saturation above 10^DIGITS-1, optional blanking.
   function automatic logic [BCD_W:0] model(input int unsigned v);
      logic [BCD_W-1:0] r;
      int unsigned x;
      bit ovf;
      ovf = (v > 999999);
      x = ovf ? 999999 : v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
`ifdef BIN2BCD_LEADING_BLANK_EN
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (r[4*i +: 4] != 4'h0) break;
         r[4*i +: 4] = 4'hF;
      end
`endif
      return {ovf, r};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; drives start so it is accepted at the next posedge,
   // returns at the negedge right after that edge (cycle n=0).
   task automatic start_pulse(input logic [IN_W-1:0] v);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Walks negedges from cycle n0 after the accepted edge until done; busy must
   // be high until then, done must appear exactly IN_W cycles after acceptance.
   task automatic wait_done(input int n0, input logic [BCD_W-1:0] e_bcd, input logic e_ovf);
      int n;
      bit got;
      n = n0;
      got = 0;
      while (!got && n <= IN_W + 5) begin
         if (done) begin
            got = 1;
         end else begin
            check("busy_during_conv", {31'd0, busy}, 32'd1);
            @(negedge clk);
            n++;
         end
      end
      if (!got) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("latency", n, IN_W);
         check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
         check("bcd_out", {8'd0, bcd_out}, {8'd0, e_bcd});
         check("overflow", {31'd0, overflow}, {31'd0, e_ovf});
      end
   endtask

   // Scoreboard path: push expected on start, pop on done.
   task automatic run_sb(input logic [IN_W-1:0] v);
      logic [BCD_W:0] e;
      exp_q.push_back(model(v));
      start_pulse(v);
      e = exp_q.pop_front();
      wait_done(0, e[BCD_W-1:0], e[BCD_W]);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [BCD_W:0] e;
      int ndone;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      start    = 1'b0;
      bin_in   = '0;

      tbl[0] = '{20'd123456,  24'h123456, 1'b0};
`ifdef BIN2BCD_LEADING_BLANK_EN
      tbl[1] = '{20'd0,       24'hFFFFF0, 1'b0};
      tbl[2] = '{20'd42,      24'hFFFF42, 1'b0};
      tbl[6] = '{20'd98765,   24'hF98765, 1'b0};
`else
      tbl[1] = '{20'd0,       24'h000000, 1'b0};
      tbl[2] = '{20'd42,      24'h000042, 1'b0};
      tbl[6] = '{20'd98765,   24'h098765, 1'b0};
`endif
      tbl[3] = '{20'd1048575, 24'h999999, 1'b1};
      tbl[4] = '{20'd999999,  24'h999999, 1'b0};
      tbl[5] = '{20'd1000000, 24'h999999, 1'b1};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_bcd", {8'd0, bcd_out}, {8'd0, BCD_RST});
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      foreach (tbl[i]) begin
         start_pulse(tbl[i].bin);
         wait_done(0, tbl[i].bcd, tbl[i].ovf);
         @(negedge clk);
         check("tbl_done_one_cycle", {31'd0, done}, 32'd0);
      end

      // Ignored start / bin_in change during conversion, then back-to-back
      start_pulse(20'd42);              // n = 0
      @(negedge clk);                   // n = 1
      @(negedge clk);                   // n = 2
      bin_in = 20'd777777;              // seen at edge k+3
      @(negedge clk);                   // n = 3
      @(negedge clk);                   // n = 4
      start  = 1'b1;                    // pulse at edge k+5
      bin_in = 20'd7;
      @(negedge clk);                   // n = 5
      start = 1'b0;
      e = model(42);
      wait_done(5, e[BCD_W-1:0], e[BCD_W]);
      // still in the done cycle: this start must be accepted
      start_pulse(20'd7);
      e = model(7);
      wait_done(0, e[BCD_W-1:0], e[BCD_W]);
      @(negedge clk);

      // Reset in the middle of a conversion
      start_pulse(20'd555555);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_overflow", {31'd0, overflow}, 32'd0);
      check("abort_bcd", {8'd0, bcd_out}, {8'd0, BCD_RST});
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (IN_W + 5) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      start_pulse(20'd555555);
      e = model(555555);
      wait_done(0, e[BCD_W-1:0], e[BCD_W]);
      @(negedge clk);

      // start held high for 63 cycles: done at k+20, k+41, k+62
      start  = 1'b1;
      bin_in = 20'd98765;
      @(posedge clk);
      e = model(98765);
      ndone = 0;
      for (int n = 0; n <= 62; n++) begin
         @(negedge clk);
         if (n == 62) start = 1'b0;
         if (n == 20 || n == 41 || n == 62) begin
            check("held_done", {31'd0, done}, 32'd1);
            check("held_bcd", {8'd0, bcd_out}, {8'd0, e[BCD_W-1:0]});
         end else if (done) begin
            ndone++;
         end
      end
      check("held_no_extra_done", ndone, 0);
      repeat (IN_W + 3) @(negedge clk);
      check("held_idle_after", {31'd0, busy}, 32'd0);

      // Random values against the reference model
      for (int i = 0; i < 20; i++) begin
         run_sb(IN_W'($urandom_range(0, (1 << IN_W) - 1)));
      end
      run_sb(20'd999998);
      run_sb(20'd1000001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
